// File: rtl/rca_self_test.sv
// Built-in self-test controller for a WIDTH-bit ripple-carry adder: exhaustively
// sweeps {a,b,cin}, samples {cout,sum} after SETTLE cycles and tallies mismatches.
module rca_self_test #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2*WIDTH + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [VW-1:0] VEC_ZERO = {VW{1'b0}};
  localparam logic [VW-1:0] VEC_ONE  = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0] VEC_MAX  = {VW{1'b1}};
  localparam logic [EW-1:0] ERR_ZERO = {EW{1'b0}};
  localparam logic [EW-1:0] ERR_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Golden sum of the operands encoded in a vector, zero-extended to WIDTH+1 bits.
  function automatic logic [WIDTH:0] ref_result(input logic [VW-1:0] v);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    op_a = v[VW-1:WIDTH+1];
    op_b = v[WIDTH:1];
    op_c = v[0];
    return {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
  endfunction

  state_t          state_q, state_d;
  logic [VW-1:0]   vec_q,   vec_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [EW-1:0]   err_q,   err_d;
  logic [VW-1:0]   ff_q,    ff_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            pass_q,  pass_d;
  logic            mismatch_s;

  // State, datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= VEC_ZERO;
      cnt_q   <= CNT_ZERO;
      err_q   <= ERR_ZERO;
      ff_q    <= VEC_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath update; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ff_d       = ff_q;
    mismatch_s = ({cout, sum} != ref_result(vec_q));
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SETTLE;
          vec_d   = VEC_ZERO;
          cnt_d   = CNT_LOAD;
          err_d   = ERR_ZERO;
          ff_d    = VEC_ZERO;
        end else begin
          state_d = state_q;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          err_d = err_q + ERR_ONE;
          if (err_q == ERR_ZERO) begin
            ff_d = vec_q;
          end else begin
            ff_d = ff_q;
          end
        end else begin
          err_d = err_q;
        end
        if (vec_q == VEC_MAX) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == ERR_ZERO);
  end

  assign a          = vec_q[VW-1:WIDTH+1];
  assign b          = vec_q[WIDTH:1];
  assign cin        = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_rca_self_test.sv
// Directed bench for rca_self_test: default instance against a good/faulty adder
// model, plus a WIDTH=2/SETTLE=1 instance with cout stuck at 1.
module tb_rca_self_test;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start2;
  int         fault_mode = 0;

  logic [3:0] a1, b1, sum1;
  logic       cin1, cout1, busy1, done1, pass1;
  logic [9:0] err1;
  logic [8:0] ff1;
  logic [4:0] add1;

  logic [1:0] a2, b2, sum2;
  logic       cin2, cout2, busy2, done2, pass2;
  logic [5:0] err2;
  logic [4:0] ff2;
  logic [2:0] add2;

  int n_checks = 0;
  int n_errors = 0;

  rca_self_test #(.WIDTH(4), .SETTLE(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  rca_self_test #(.WIDTH(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .cin(cin2), .sum(sum2), .cout(cout2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2)
  );

  // Adder model: 0 = correct, 1 = cout stuck at 0, 2 = sum[0] inverted.
  always_comb begin
    add1 = {1'b0, a1} + {1'b0, b1} + {4'b0000, cin1};
    sum1 = add1[3:0];
    cout1 = add1[4];
    if (fault_mode == 1) begin
      cout1 = 1'b0;
    end else if (fault_mode == 2) begin
      sum1[0] = ~add1[0];
    end
  end

  // Small adder with cout stuck at 1.
  always_comb begin
    add2  = {1'b0, a2} + {1'b0, b2} + {2'b00, cin2};
    sum2  = add2[1:0];
    cout2 = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start, then count busy cycles until done; optionally re-pulse start mid-sweep.
  task automatic run_sweep1(input int glitch_at, output int bcyc, output bit ok);
    int guard;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bcyc  = 0;
    guard = 0;
    while (!done1 && guard < 4000) begin
      if (busy1) bcyc++;
      if (glitch_at >= 0 && bcyc >= glitch_at && bcyc < glitch_at + 3) start1 = 1'b1;
      else start1 = 1'b0;
      @(negedge clk);
      guard++;
    end
    start1 = 1'b0;
    ok = done1;
  endtask

  task automatic run_sweep2(output int bcyc, output bit ok);
    int guard;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bcyc  = 0;
    guard = 0;
    while (!done2 && guard < 300) begin
      if (busy2) bcyc++;
      @(negedge clk);
      guard++;
    end
    ok = done2;
  endtask

  initial begin
    int bcyc;
    bit ok;
    int guard;

    fault_mode = 0;
    do_reset();
    check_eq("rst_ops",   32'({a1, b1, cin1}), 32'd0);
    check_eq("rst_busy",  32'(busy1), 32'd0);
    check_eq("rst_done",  32'(done1), 32'd0);
    check_eq("rst_pass",  32'(pass1), 32'd0);
    check_eq("rst_err",   32'(err1),  32'd0);
    check_eq("rst_ff",    32'(ff1),   32'd0);

    // Good adder.
    run_sweep1(-1, bcyc, ok);
    check_eq("good_done",  32'(ok),   32'd1);
    check_eq("good_busy",  32'(bcyc), 32'd1536);
    check_eq("good_pass",  32'(pass1), 32'd1);
    check_eq("good_err",   32'(err1),  32'd0);
    check_eq("good_ff",    32'(ff1),   32'd0);
    check_eq("good_hold",  32'({a1, b1, cin1}), 32'h1FF);

    // start held in DONE restarts immediately.
    start1 = 1'b1;
    @(negedge clk);
    check_eq("restart_done", 32'(done1), 32'd0);
    check_eq("restart_busy", 32'(busy1), 32'd1);
    check_eq("restart_ops",  32'({a1, b1, cin1}), 32'd0);
    @(negedge clk);
    start1 = 1'b0;
    do_reset();

    // cout stuck at 0.
    fault_mode = 1;
    run_sweep1(-1, bcyc, ok);
    check_eq("c0_done", 32'(ok),    32'd1);
    check_eq("c0_err",  32'(err1),  32'd256);
    check_eq("c0_ff",   32'(ff1),   32'h1F);
    check_eq("c0_pass", 32'(pass1), 32'd0);

    // sum[0] inverted, started straight from DONE.
    fault_mode = 2;
    run_sweep1(-1, bcyc, ok);
    check_eq("s0_done", 32'(ok),    32'd1);
    check_eq("s0_busy", 32'(bcyc),  32'd1536);
    check_eq("s0_err",  32'(err1),  32'd512);
    check_eq("s0_ff",   32'(ff1),   32'd0);
    check_eq("s0_pass", 32'(pass1), 32'd0);

    // Reset mid-sweep at vector 100, with errors already accumulated.
    fault_mode = 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    guard = 0;
    while ({a1, b1, cin1} != 9'd100 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("mid_reached", 32'({a1, b1, cin1}), 32'd100);
    check_eq("mid_err_pre", 32'(err1 != 10'd0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ops",  32'({a1, b1, cin1}), 32'd0);
    check_eq("mid_rst_busy", 32'(busy1), 32'd0);
    check_eq("mid_rst_done", 32'(done1), 32'd0);
    check_eq("mid_rst_pass", 32'(pass1), 32'd0);
    check_eq("mid_rst_err",  32'(err1),  32'd0);
    check_eq("mid_rst_ff",   32'(ff1),   32'd0);
    rst = 1'b0;
    fault_mode = 0;
    run_sweep1(-1, bcyc, ok);
    check_eq("mid_re_done", 32'(ok),    32'd1);
    check_eq("mid_re_busy", 32'(bcyc),  32'd1536);
    check_eq("mid_re_pass", 32'(pass1), 32'd1);

    // start pulses during SETTLE/CHECK are ignored.
    fault_mode = 1;
    run_sweep1(700, bcyc, ok);
    check_eq("gl_done", 32'(ok),   32'd1);
    check_eq("gl_busy", 32'(bcyc), 32'd1536);
    check_eq("gl_err",  32'(err1), 32'd256);
    check_eq("gl_ff",   32'(ff1),  32'h1F);

    // WIDTH=2, SETTLE=1, cout stuck at 1.
    run_sweep2(bcyc, ok);
    check_eq("w2_done", 32'(ok),    32'd1);
    check_eq("w2_busy", 32'(bcyc),  32'd64);
    check_eq("w2_err",  32'(err2),  32'd16);
    check_eq("w2_ff",   32'(ff2),   32'd0);
    check_eq("w2_pass", 32'(pass2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
